cgra_core_timing_model: RTL
===========================

Name: cgra_core_timing_model

Overview:
- Parametrised, cycle-accurate behavioural model of a CGRA core, used to exercise the CTA dispatcher.
- Accepts CTA descriptors into MAX_CTA slots and holds each for a latency drawn from a selectable generator.
- Returns completions with configurable ordering (in-order or out-of-order) and a hold-stable done handshake.
- Adds a timer stall input and occupancy/completion counters for scoreboarding.

Parameters:
CORE_ID, 0, core index, used only in trace output
MAX_CTA, 4, number of CTA slots (>=1)
LAT_W, 8, timer width
MIN_LAT, 10, minimum latency in cycles (>=1)
MAX_LAT, 40, maximum latency in cycles (>=MIN_LAT, <2**LAT_W)
LAT_MODE, 1, 0=fixed MIN_LAT; 1=LFSR random in [MIN_LAT,MAX_LAT]; 2=ramp (MIN_LAT+k mod range, k=accept count)
IN_ORDER, 0, 1=completions released strictly in grant order
LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit LFSR

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sm_grant_valid  in  1  dispatcher offers CTA
sm_grant_ready  out  1  free slot available
sm_grant_ctx  in  $bits(dice_pkg::dice_cta_desc_t)  CTA descriptor; only .cta_id is stored
sm_done_valid  out  1  completion presented
sm_done_ready  in  1  dispatcher accepts completion
sm_done_cta_id  out  $bits(dice_pkg::dice_cta_id_t)  completed CTA id, '0 when not valid
cfg_stall  in  1  freeze all timers
active_cnt  out  $clog2(MAX_CTA+1)  occupied slots
done_count  out  32  completions handshaken, wraps at 2**32

Behaviour:
- Reset: clk, rst_n asynchronous active-low. On reset:
  - all slots invalid, timers/ids/ages 0; LFSR=LFSR_SEED; ramp k=0; lock clear.
  - Outputs: sm_grant_ready=1, sm_done_valid=0, sm_done_cta_id=0, active_cnt=0, done_count=0.
  - Reset mid-operation discards all in-flight CTAs silently.
- Slot state: per slot valid, id, timer[LAT_W], age[$clog2(MAX_CTA)]. Ages of valid slots are always distinct, in 0..active_cnt-1; the largest age is the oldest slot.
- Grant:
  - sm_grant_ready=1 iff any slot is invalid, computed from registered state only. A slot released this cycle is not reusable until the next cycle.
  - On handshake: the lowest-index free slot gets valid=1, id=ctx.cta_id, timer=L, age=0; all other valid slots age+1.
- Latency L:
  - Mode 0: L=MIN_LAT.
  - Mode 1: L=MIN_LAT + (lfsr % (MAX_LAT-MIN_LAT+1)). The LFSR (Galois, taps 16,14,13,11) advances one step per grant handshake only.
  - Mode 2: L=MIN_LAT + (k % (MAX_LAT-MIN_LAT+1)); k increments per grant.
- Timers:
  - Each valid slot with timer!=0 decrements by 1 per cycle while cfg_stall=0; a timer never decrements in its load cycle.
  - A grant handshaken at edge E first shows sm_done_valid in the cycle after edge E+L, i.e. L cycles after acceptance with no stall.
  - A slot is expired when valid && timer==0.
- Done selection:
  - IN_ORDER=1: candidate is the oldest slot; it is presented only if expired. Younger expired slots wait.
  - IN_ORDER=0: candidate is the lowest-index expired slot.
  - Once sm_done_valid is high without sm_done_ready, the selected slot is locked. valid and id are held stable until handshake, even if a lower-index slot expires meanwhile.
- Done handshake: the slot is invalidated, slots older-than... i.e. ages greater than the released age decrement by 1, done_count+1, lock cleared.
- Simultaneous grant and done in one cycle:
  - Both take effect.
  - Age update for other slots is +1 (grant) and -1 (if older than released), applied together.
  - active_cnt unchanged.
- cfg_stall affects timers only; both handshakes remain live.
- Elaboration checks: $error if MIN_LAT<1, MAX_LAT<MIN_LAT, MAX_LAT>=2**LAT_W, LFSR_SEED==0, or LAT_MODE>2.

Optional Feature:
CGRA_MODEL_TRACE_EN
- Defined: a $display is printed on every grant and done handshake, with time, CORE_ID, CTA x/y/z and latency L (grant only). Concurrent assertions fire $error if:
  - sm_done_cta_id changes while sm_done_valid && !sm_done_ready;
  - sm_grant_valid && !sm_grant_ready persists beyond 10000 cycles (deadlock).
- Undefined: no prints, no assertions; functional behaviour identical.

Test Plan:
- Fixed latency: LAT_MODE=0, MIN_LAT=10, single grant id x=3 at cycle 5, done_ready=1 -> sm_done_valid in cycle 15 only, id x=3, done_count=1, active_cnt back to 0.
- Full: MAX_CTA=4, 5 back-to-back grants -> 4 accepted, ready=0. The 5th is accepted the cycle after the first done handshake, and active_cnt never exceeds 4.
- Ordering: IN_ORDER=1, LAT_MODE=2, MIN_LAT=5, MAX_LAT=6; grants A then B one cycle apart (L=5,6) and C with L=5. Done order must be A,B,C. Repeating with IN_ORDER=0 and slot0 held, the lowest-index expired slot goes first.
- Backpressure lock: IN_ORDER=0, slot1 expires and is presented; done_ready=0 for 20 cycles while slot0 expires -> id stays slot1's value. After ready, slot1 completes, then slot0 next cycle.
- Stall: MIN_LAT=10, cfg_stall=1 for 5 cycles mid-countdown -> done asserted exactly 15 cycles after grant; grant handshakes during the stall are still accepted.
- Reset mid-run: 3 CTAs active, pulse rst_n low -> done_valid=0 and active_cnt=0 immediately, grant_ready=1. After release, LAT_MODE=1 latencies repeat the post-reset sequence from the first run.

Source files
------------

// File: rtl/cgra_core_timing_model_if.sv
// cgra_core_timing_model_if: CTA descriptor types plus grant/done handshake bundle between dispatcher and core model
package dice_pkg;
  typedef struct packed {
    logic [7:0] z;
    logic [7:0] y;
    logic [7:0] x;
  } dice_cta_id_t;
  typedef struct packed {
    dice_cta_id_t cta_id;
  } dice_cta_desc_t;
endpackage

interface cgra_core_timing_model_if;
  logic                  sm_grant_valid;
  logic                  sm_grant_ready;
  dice_pkg::dice_cta_desc_t sm_grant_ctx;
  logic                  sm_done_valid;
  logic                  sm_done_ready;
  dice_pkg::dice_cta_id_t   sm_done_cta_id;
  modport master (
    output sm_grant_valid, sm_grant_ctx, sm_done_ready,
    input  sm_grant_ready, sm_done_valid, sm_done_cta_id
  );
  modport slave (
    input  sm_grant_valid, sm_grant_ctx, sm_done_ready,
    output sm_grant_ready, sm_done_valid, sm_done_cta_id
  );
endinterface

// File: rtl/cgra_core_timing_model.sv
// cgra_core_timing_model: slot-based CGRA core latency model; define CGRA_MODEL_TRACE_EN for handshake trace and protocol assertions
module cgra_core_timing_model #(
  parameter int          CORE_ID   = 0,
  parameter int          MAX_CTA   = 4,
  parameter int          LAT_W     = 8,
  parameter int          MIN_LAT   = 10,
  parameter int          MAX_LAT   = 40,
  parameter int          LAT_MODE  = 1,
  parameter int          IN_ORDER  = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         CW        = $clog2(MAX_CTA + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cgra_core_timing_model_if.slave       sm,
  input  logic                          cfg_stall,
  output logic [CW-1:0]                 active_cnt,
  output logic [31:0]                   done_count
);
  localparam int AW    = MAX_CTA > 1 ? $clog2(MAX_CTA) : 1;
  localparam int RANGE = MAX_LAT - MIN_LAT + 1;

  if (MIN_LAT < 1 || MAX_LAT < MIN_LAT || MAX_LAT >= 2 ** LAT_W || LFSR_SEED == 16'h0 || LAT_MODE > 2) begin : g_bad_cfg
    $error("cgra_core_timing_model: illegal latency/LFSR parameter set");
  end

  logic [MAX_CTA-1:0]     valid_q;
  dice_pkg::dice_cta_id_t id_q [MAX_CTA];
  logic [LAT_W-1:0]       timer_q [MAX_CTA];
  logic [AW-1:0]          age_q [MAX_CTA];
  logic [CW-1:0]          cnt_q;
  logic [15:0]            lfsr_q;
  logic [LAT_W-1:0]       ramp_q;
  logic [LAT_W-1:0]       lat;
  logic                   lock_q;
  logic [AW-1:0]          lock_idx_q;
  logic                   free_found, exp_found, old_found, done_valid, gnt, dn;
  logic [AW-1:0]          free_idx, exp_idx, old_idx, sel;

  // Slot scan: lowest free slot, lowest expired slot and the oldest slot
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    exp_found  = 1'b0;
    exp_idx    = '0;
    old_found  = 1'b0;
    old_idx    = '0;
    for (int i = MAX_CTA - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = AW'(i);
      end
      if (valid_q[i] && timer_q[i] == '0) begin
        exp_found = 1'b1;
        exp_idx   = AW'(i);
      end
      if (valid_q[i] && age_q[i] == AW'(cnt_q - 1'b1)) begin
        old_found = 1'b1;
        old_idx   = AW'(i);
      end
    end
  end

  // A locked presentation always wins so id stays stable under backpressure
  assign sel        = lock_q ? lock_idx_q : IN_ORDER != 0 ? old_idx : exp_idx;
  assign done_valid = lock_q || (IN_ORDER != 0 ? old_found && timer_q[old_idx] == '0 : exp_found);
  assign lat        = LAT_MODE == 0 ? LAT_W'(MIN_LAT) :
                      LAT_MODE == 1 ? LAT_W'(MIN_LAT + int'(lfsr_q) % RANGE) :
                      LAT_W'(MIN_LAT) + ramp_q;
  assign gnt        = sm.sm_grant_valid && free_found;
  assign dn         = done_valid && sm.sm_done_ready;

  assign sm.sm_grant_ready = free_found;
  assign sm.sm_done_valid  = done_valid;
  assign sm.sm_done_cta_id = done_valid ? id_q[sel] : '0;
  assign active_cnt        = cnt_q;

  // Slot allocation, countdown, ageing, latency generators and completion bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_CTA; i++) begin
        valid_q[i] <= 1'b0;
        id_q[i]    <= '0;
        timer_q[i] <= '0;
        age_q[i]   <= '0;
      end
      cnt_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      ramp_q     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      done_count <= '0;
    end else begin
      for (int i = 0; i < MAX_CTA; i++) begin
        if (gnt && free_idx == AW'(i)) begin
          valid_q[i] <= 1'b1;
          id_q[i]    <= sm.sm_grant_ctx.cta_id;
          timer_q[i] <= lat;
          age_q[i]   <= '0;
        end else if (dn && sel == AW'(i)) begin
          valid_q[i] <= 1'b0;
        end else if (valid_q[i]) begin
          if (!cfg_stall && timer_q[i] != '0) timer_q[i] <= timer_q[i] - 1'b1;
          age_q[i] <= age_q[i] + AW'(gnt) - AW'(dn && age_q[i] > age_q[sel]);
        end
      end
      cnt_q <= cnt_q + CW'(gnt) - CW'(dn);
      if (gnt) begin
        lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        ramp_q <= ramp_q == LAT_W'(RANGE - 1) ? '0 : ramp_q + 1'b1;
      end
      lock_q     <= done_valid && !sm.sm_done_ready;
      lock_idx_q <= sel;
      done_count <= done_count + 32'(dn);
    end
  end

`ifdef CGRA_MODEL_TRACE_EN
  logic [13:0] blocked_cyc;

  // Handshake trace
  always_ff @(posedge clk) begin
    if (rst_n && gnt)
      $display("%0t core%0d grant x=%0d y=%0d z=%0d L=%0d", $time, CORE_ID, sm.sm_grant_ctx.cta_id.x,
               sm.sm_grant_ctx.cta_id.y, sm.sm_grant_ctx.cta_id.z, lat);
    if (rst_n && dn)
      $display("%0t core%0d done x=%0d y=%0d z=%0d", $time, CORE_ID, sm.sm_done_cta_id.x,
               sm.sm_done_cta_id.y, sm.sm_done_cta_id.z);
  end

  // Consecutive cycles a grant is offered but refused
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blocked_cyc <= '0;
    else blocked_cyc <= sm.sm_grant_valid && !free_found ? (blocked_cyc == 14'h3FFF ? blocked_cyc : blocked_cyc + 1'b1) : '0;
  end

  a_done_stable: assert property (@(posedge clk) disable iff (!rst_n)
    sm.sm_done_valid && !sm.sm_done_ready |=> $stable(sm.sm_done_cta_id))
    else $error("core%0d done id changed under backpressure", CORE_ID);

  a_no_deadlock: assert property (@(posedge clk) disable iff (!rst_n) blocked_cyc < 14'd10000)
    else $error("core%0d grant blocked for 10000 cycles", CORE_ID);
`else
  logic unused_core;
  assign unused_core = ^32'(CORE_ID);
`endif
endmodule
